// File: rtl/ibuff_ctrl_if.sv
// ibuff_ctrl_if: fetch/dispatch handshake and RAM addressing bundle for the instruction buffer controller
interface ibuff_ctrl_if #(
    parameter int INDEX    = 5,
    parameter int WR_PORTS = 8,
    parameter int RD_PORTS = 4
);
    logic                      flush_i;
    logic                      fetchValid_i;
    logic [WR_PORTS-1:0]       fetchMask_i;
    logic                      stall_o;
    logic [WR_PORTS-1:0]       we_o;
    logic [WR_PORTS*INDEX-1:0] wrAddr_o;
    logic [RD_PORTS*INDEX-1:0] rdAddr_o;
    logic                      dispatchValid_o;
    logic                      dispatchReady_i;
    logic [INDEX:0]            count_o;

    modport master (
        output flush_i, fetchValid_i, fetchMask_i, dispatchReady_i,
        input  stall_o, we_o, wrAddr_o, rdAddr_o, dispatchValid_o, count_o
    );

    modport slave (
        input  flush_i, fetchValid_i, fetchMask_i, dispatchReady_i,
        output stall_o, we_o, wrAddr_o, rdAddr_o, dispatchValid_o, count_o
    );
endinterface

// File: rtl/ibuff_ctrl.sv
// ibuff_ctrl: head/tail/occupancy controller for the multi-port instruction buffer RAM
module ibuff_ctrl #(
    parameter int DEPTH    = 32,
    parameter int INDEX    = 5,
    parameter int WR_PORTS = 8,
    parameter int RD_PORTS = 4
) (
    input logic clk,
    input logic reset,
    ibuff_ctrl_if.slave bus
);
    localparam logic [INDEX:0] DEPTH_W = (INDEX+1)'(DEPTH);
    localparam logic [INDEX:0] WR_W    = (INDEX+1)'(WR_PORTS);
    localparam logic [INDEX:0] RD_W    = (INDEX+1)'(RD_PORTS);

    logic [INDEX-1:0] head, tail;
    logic [INDEX:0]   count, total;
    logic             stall, accept, dvalid, pop;

    // stall and handshake decisions; stall looks only at registered occupancy
    always_comb begin
        stall               = (DEPTH_W - count) < WR_W;
        accept              = bus.fetchValid_i & ~stall & ~bus.flush_i;
        dvalid              = (count >= RD_W) & ~bus.flush_i;
        pop                 = dvalid & bus.dispatchReady_i;
        bus.stall_o         = stall;
        bus.we_o            = accept ? bus.fetchMask_i : '0;
        bus.dispatchValid_o = dvalid;
        bus.count_o         = count;
    end

    // compacted write addresses: each slot lands at tail plus the number of set slots below it
    always_comb begin
        total        = '0;
        bus.wrAddr_o = '0;
        bus.rdAddr_o = '0;
        for (int i = 0; i < WR_PORTS; i++) begin
            bus.wrAddr_o[i*INDEX +: INDEX] = tail + total[INDEX-1:0];
            total = total + (INDEX+1)'(bus.fetchMask_i[i]);
        end
        for (int j = 0; j < RD_PORTS; j++)
            bus.rdAddr_o[j*INDEX +: INDEX] = head + INDEX'(j);
    end

    // pointer and occupancy update; flush and reset both empty the buffer
    always_ff @(posedge clk) begin
        if (reset || bus.flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept)
                tail <= tail + total[INDEX-1:0];
            if (pop)
                head <= head + RD_W[INDEX-1:0];
            count <= count + (accept ? total : '0) - (pop ? RD_W : '0);
        end
    end
endmodule

// File: tb/tb_ibuff_ctrl.sv
// tb_ibuff_ctrl: randomized scoreboard bench for ibuff_ctrl against a queue-of-entries model
module tb_ibuff_ctrl;
    typedef struct packed {
        logic        stall;
        logic [7:0]  we;
        logic [39:0] wr;
        logic [19:0] rd;
        logic        dv;
        logic [5:0]  cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    ibuff_ctrl_if bus ();
    ibuff_ctrl dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    exp_t sb[$];
    int   fifo[$];
    int   wp = 0;
    int   vectors = 0;
    int   miscompares = 0;
    bit   started = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // one clock of stimulus: predict outputs from the entry queue, then advance the model
    task automatic cycle(input bit rst, input bit fl, input bit fv, input logic [7:0] m, input bit rdy);
        exp_t e;
        int   cnt, head, below;
        bit   acc, pop;
        reset               = rst;
        bus.flush_i         = fl;
        bus.fetchValid_i    = fv;
        bus.fetchMask_i     = m;
        bus.dispatchReady_i = rdy;
        cnt  = fifo.size();
        head = (wp - cnt + 32) % 32;
        acc  = fv && (32 - cnt >= 8) && !fl;
        pop  = (cnt >= 4) && !fl && rdy;
        e.stall = (32 - cnt) < 8;
        e.we    = acc ? m : 8'h00;
        e.dv    = (cnt >= 4) && !fl;
        e.cnt   = 6'(cnt);
        e.wr    = '0;
        e.rd    = '0;
        for (int i = 0; i < 8; i++) begin
            below = 0;
            for (int k = 0; k < i; k++) below += int'(m[k]);
            e.wr[i*5 +: 5] = 5'((wp + below) % 32);
        end
        for (int j = 0; j < 4; j++) e.rd[j*5 +: 5] = 5'((head + j) % 32);
        if (started) sb.push_back(e);
        @(posedge clk);
        if (rst || fl) begin
            fifo.delete();
            wp = 0;
        end else begin
            if (pop) repeat (4) void'(fifo.pop_front());
            if (acc)
                for (int i = 0; i < 8; i++)
                    if (m[i]) begin
                        fifo.push_back(wp);
                        wp = (wp + 1) % 32;
                    end
        end
        #1;
    endtask

    // monitor: every cycle the DUT presents its outputs, compare against the oldest prediction
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk("stall", 64'(bus.stall_o), 64'(e.stall));
            chk("we", 64'(bus.we_o), 64'(e.we));
            chk("wrAddr", 64'(bus.wrAddr_o), 64'(e.wr));
            chk("rdAddr", 64'(bus.rdAddr_o), 64'(e.rd));
            chk("dispatchValid", 64'(bus.dispatchValid_o), 64'(e.dv));
            chk("count", 64'(bus.count_o), 64'(e.cnt));
        end
    end

    initial begin
        cycle(1, 0, 0, 8'h00, 0);
        cycle(1, 0, 0, 8'h00, 0);
        started = 1;
        cycle(0, 0, 0, 8'h00, 0);
        cycle(0, 0, 1, 8'hFF, 0);
        cycle(0, 0, 1, 8'hFF, 0);
        cycle(0, 0, 1, 8'hA5, 0);
        cycle(0, 0, 1, 8'hFF, 1);
        cycle(0, 0, 1, 8'hFF, 0);
        cycle(0, 0, 1, 8'hFF, 0);
        cycle(0, 1, 1, 8'hFF, 1);
        cycle(0, 0, 0, 8'h00, 1);
        for (int p = 0; p < 6; p++) begin
            for (int c = 0; c < 150; c++) begin
                logic [7:0] m;
                m = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
                cycle(0, $urandom_range(0, 40) == 0, $urandom_range(0, 4) != 0, m,
                      $urandom_range(0, 9) < ((p % 2 == 0) ? 3 : 9));
            end
            cycle(1, 0, 1, 8'hFF, 1);
        end
        cycle(0, 0, 0, 8'h00, 0);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
